surf_trig_rx_decoder: RTL and testbench

// - Receive end of the SURF trigger-word AXI4-Stream. Accepts 32-bit trigger words
//   {2'b10, addr[11:0], 2'b00, 8'h00, meta[7:0]} and checks their format.
// - Decodes address and metadata into a buffered event stream for downstream readout.
// - Keeps trigger/error counters and optional address-spacing (holdoff) checking.
// - Sits in the ifclk domain on the consumer side of the trigger generator.

---
 rtl/surf_trig_rx_decoder.sv | 126 ++++++++++++
 tb/tb_surf_trig_rx_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_trig_rx_decoder.sv
// SURF trigger-word receiver: format check, address/meta decode, event FIFO and counters.
// Optional address-spacing check enabled by defining SURF_TRIG_RX_SPACING_CHECK_EN.
module surf_trig_rx_decoder #(
    parameter int unsigned MIN_SPACING = 8,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic        ifclk,
    input  logic        ifclk_rstn_i,
    input  logic [31:0] trig_tdata,
    input  logic        trig_tvalid,
    output logic        trig_tready,
    output logic [11:0] evt_addr_o,
    output logic [7:0]  evt_meta_o,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    input  logic        clear_i,
    output logic [15:0] trig_count_o,
    output logic [7:0]  fmt_err_count_o,
    output logic        fmt_err_o,
    output logic        spacing_err_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic          r_alive;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [19:0]   r_mem [FIFO_DEPTH];
    logic [15:0]   r_trig_count;
    logic [7:0]    r_fmt_cnt;
    logic          r_fmt_err;
    logic          r_spc_err;
    logic          r_trk_valid;
    logic [11:0]   r_last_addr;

    logic          w_xfer;
    logic          w_good;
    logic          w_push;
    logic          w_bad;
    logic          w_pop;
    logic          w_spc_viol;
    logic [11:0]   w_addr;

    // Ready depends only on registered state; r_alive holds it low until the first clock after reset.
    assign trig_tready = r_alive && (r_count != CW'(FIFO_DEPTH));
    assign w_xfer      = trig_tvalid && trig_tready;
    assign w_good      = (trig_tdata[31:30] == 2'b10) && (trig_tdata[17:16] == 2'b00)
                         && (trig_tdata[15:8] == 8'h00);
    assign w_push      = w_xfer && w_good;
    assign w_bad       = w_xfer && !w_good;
    assign w_addr      = trig_tdata[29:18];

    assign evt_valid_o = (r_count != '0);
    assign w_pop       = evt_valid_o && evt_ready_i;
    assign {evt_addr_o, evt_meta_o} = r_mem[r_rptr];

    assign trig_count_o    = r_trig_count;
    assign fmt_err_count_o = r_fmt_cnt;
    assign fmt_err_o       = r_fmt_err;
    assign spacing_err_o   = r_spc_err;

`ifdef SURF_TRIG_RX_SPACING_CHECK_EN
    logic [11:0] w_diff;
    assign w_diff     = w_addr - r_last_addr;
    assign w_spc_viol = r_trk_valid && (32'(w_diff) < MIN_SPACING);
`else
    assign w_spc_viol = 1'b0;
`endif

    always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            r_alive <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_alive <= 1'b1;
            if (w_push) begin
                r_mem[r_wptr] <= {w_addr, trig_tdata[7:0]};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // clear_i wins over any count/flag/tracker update in the same cycle.
    always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            r_trig_count <= '0;
            r_fmt_cnt    <= '0;
            r_fmt_err    <= 1'b0;
            r_spc_err    <= 1'b0;
            r_trk_valid  <= 1'b0;
            r_last_addr  <= '0;
        end else if (clear_i) begin
            r_trig_count <= '0;
            r_fmt_cnt    <= '0;
            r_fmt_err    <= 1'b0;
            r_spc_err    <= 1'b0;
            r_trk_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_trig_count <= r_trig_count + 16'd1;
                r_last_addr  <= w_addr;
                r_trk_valid  <= 1'b1;
                if (w_spc_viol) begin
                    r_spc_err <= 1'b1;
                end
            end
            if (w_bad) begin
                r_fmt_err <= 1'b1;
                if (r_fmt_cnt != 8'hFF) begin
                    r_fmt_cnt <= r_fmt_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_surf_trig_rx_decoder.sv
// Randomized bench for surf_trig_rx_decoder with a queue-based reference model.
// Spacing checks follow SURF_TRIG_RX_SPACING_CHECK_EN like the DUT.
module tb_surf_trig_rx_decoder;
    localparam int unsigned MIN_SPACING = 8;
    localparam int unsigned FIFO_DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] trig_tdata;
    logic        trig_tvalid;
    logic        trig_tready;
    logic [11:0] evt_addr_o;
    logic [7:0]  evt_meta_o;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic        clear_i;
    logic [15:0] trig_count_o;
    logic [7:0]  fmt_err_count_o;
    logic        fmt_err_o;
    logic        spacing_err_o;

    surf_trig_rx_decoder #(
        .MIN_SPACING(MIN_SPACING),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ifclk          (clk),
        .ifclk_rstn_i   (rst_n),
        .trig_tdata     (trig_tdata),
        .trig_tvalid    (trig_tvalid),
        .trig_tready    (trig_tready),
        .evt_addr_o     (evt_addr_o),
        .evt_meta_o     (evt_meta_o),
        .evt_valid_o    (evt_valid_o),
        .evt_ready_i    (evt_ready_i),
        .clear_i        (clear_i),
        .trig_count_o   (trig_count_o),
        .fmt_err_count_o(fmt_err_count_o),
        .fmt_err_o      (fmt_err_o),
        .spacing_err_o  (spacing_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_good(input logic [31:0] w);
        return (w[31:30] == 2'b10) && (w[17:16] == 2'b00) && (w[15:8] == 8'h00);
    endfunction

    function automatic logic [31:0] good_word(input int addr, input int meta);
        return (32'h2 << 30) | ((32'(addr) % 4096) << 18) | (32'(meta) & 32'hFF);
    endfunction

    function automatic logic [31:0] bad_word();
        logic [31:0] w;
        w = $urandom;
        if (is_good(w)) w[31] = 1'b0;
        return w;
    endfunction

    // Reference model: event queue plus counters derived from the word rules.
    logic [19:0] q[$];
    bit m_alive;
    int m_trig, m_fmt, m_last;
    bit m_fmt_err, m_spc_err, m_trk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_alive = 0; m_trig = 0; m_fmt = 0; m_last = 0;
            m_fmt_err = 0; m_spc_err = 0; m_trk = 0;
        end else begin
            bit xfer, pop, good;
            int addr, diff;
            xfer = trig_tvalid && m_alive && (q.size() != FIFO_DEPTH);
            pop  = (q.size() != 0) && evt_ready_i;
            good = is_good(trig_tdata);
            addr = int'(trig_tdata) >>> 18 & 12'hFFF;
            addr = (int'(trig_tdata >> 18)) % 4096;
            if (pop) void'(q.pop_front());
            if (xfer && good) q.push_back({addr[11:0], trig_tdata[7:0]});
            if (clear_i) begin
                m_trig = 0; m_fmt = 0; m_fmt_err = 0; m_spc_err = 0; m_trk = 0;
            end else begin
                if (xfer && good) begin
                    m_trig = (m_trig + 1) % 65536;
`ifdef SURF_TRIG_RX_SPACING_CHECK_EN
                    diff = (addr - m_last + 4096) % 4096;
                    if (m_trk && diff < int'(MIN_SPACING)) m_spc_err = 1;
`else
                    diff = 0;
`endif
                    m_last = addr;
                    m_trk  = 1;
                end
                if (xfer && !good) begin
                    if (m_fmt < 255) m_fmt++;
                    m_fmt_err = 1;
                end
            end
            m_alive = 1;
        end
    end

    always @(negedge clk) begin
        check("tready", 32'(trig_tready), 32'(m_alive && (q.size() != FIFO_DEPTH)));
        check("evt_valid", 32'(evt_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) check("evt_fields", {12'b0, evt_addr_o, evt_meta_o}, 32'(q[0]));
        if (!rst_n) check("rst_fields", {12'b0, evt_addr_o, evt_meta_o}, 32'h0);
        check("trig_count", 32'(trig_count_o), 32'(m_trig));
        check("fmt_count", 32'(fmt_err_count_o), 32'(m_fmt));
        check("fmt_err", 32'(fmt_err_o), 32'(m_fmt_err));
        check("spc_err", 32'(spacing_err_o), 32'(m_spc_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        trig_tdata  = w;
        trig_tvalid = 1'b1;
        tick();
        trig_tvalid = 1'b0;
    endtask

    initial begin
        int accepted, seen, idx, last_a;
        rst_n = 1'b0; trig_tdata = '0; trig_tvalid = 1'b0; evt_ready_i = 1'b0; clear_i = 1'b0;
        repeat (3) tick();
        check("lit_tready_in_reset", 32'(trig_tready), 32'h0);
        rst_n = 1'b1;
        #1 check("lit_tready_after_release", 32'(trig_tready), 32'h0);
        tick();
        check("lit_tready_first_clk", 32'(trig_tready), 32'h1);

        // Single good word.
        evt_ready_i = 1'b1;
        send(32'h8004_0012);
        check("lit_t1_valid", 32'(evt_valid_o), 32'h1);
        check("lit_t1_addr", 32'(evt_addr_o), 32'd1);
        check("lit_t1_meta", 32'(evt_meta_o), 32'h12);
        check("lit_t1_count", 32'(trig_count_o), 32'd1);
        tick();

        // Malformed words and saturation.
        send(32'hC000_0000);
        send(32'h8000_0100);
        check("lit_t2_fmt_cnt", 32'(fmt_err_count_o), 32'd2);
        check("lit_t2_fmt_err", 32'(fmt_err_o), 32'd1);
        check("lit_t2_no_valid", 32'(evt_valid_o), 32'd0);
        for (int i = 0; i < 300; i++) send(bad_word());
        check("lit_t2_sat", 32'(fmt_err_count_o), 32'd255);

        // Backpressure fills exactly FIFO_DEPTH entries, then drains in order.
        evt_ready_i = 1'b0;
        accepted = 0; idx = 0;
        trig_tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            trig_tdata = good_word(200 + 20 * idx, idx);
            if (trig_tready) begin accepted++; idx++; end
            tick();
        end
        trig_tvalid = 1'b0;
        check("lit_t3_accepted", 32'(accepted), 32'(FIFO_DEPTH));
        check("lit_t3_tready", 32'(trig_tready), 32'h0);
        check("lit_t3_head_addr", 32'(evt_addr_o), 32'd200);
        evt_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (evt_valid_o && seen == i) seen++;
            tick();
        end
        check("lit_t3_drain_run", 32'(seen), 32'(FIFO_DEPTH));

`ifdef SURF_TRIG_RX_SPACING_CHECK_EN
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        send(good_word(100, 1));
        send(good_word(107, 2));
        check("lit_t4_spc_set", 32'(spacing_err_o), 32'd1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        send(good_word(4092, 3));
        send(good_word(4, 4));
        check("lit_t4_spc_wrap", 32'(spacing_err_o), 32'd0);
        tick();
`endif

        // clear_i with a good word in the same cycle.
        repeat (2) tick();
        clear_i = 1'b1;
        send(good_word(300, 8'h5A));
        clear_i = 1'b0;
        check("lit_t5_count_cleared", 32'(trig_count_o), 32'd0);
        check("lit_t5_evt_valid", 32'(evt_valid_o), 32'd1);
        check("lit_t5_evt_addr", 32'(evt_addr_o), 32'd300);
        tick();

        // Async reset while two events are queued.
        evt_ready_i = 1'b0;
        send(good_word(10, 1));
        send(good_word(30, 2));
        #2 rst_n = 1'b0;
        #1 check("lit_t5_rst_flush", 32'(evt_valid_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the model.
        last_a = 0;
        for (int i = 0; i < 1500; i++) begin
            trig_tvalid = ($urandom_range(0, 9) < 7);
            evt_ready_i = ($urandom_range(0, 9) < 6);
            clear_i     = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) < 6) begin
                if ($urandom_range(0, 1) == 1) last_a = (last_a + int'($urandom_range(0, 15))) % 4096;
                else last_a = int'($urandom_range(0, 4095));
                trig_tdata = good_word(last_a, int'($urandom_range(0, 255)));
            end else begin
                trig_tdata = bad_word();
            end
            tick();
        end
        trig_tvalid = 1'b0; clear_i = 1'b0; evt_ready_i = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
